// File: rtl/scr1_axi_mem_bridge.sv
// Single-outstanding bridge from the core request/response memory port to an AXI4 master.
// Issues single-beat transactions, aligns byte lanes and folds AXI responses into OK/ERR.
module scr1_axi_mem_bridge #(
  parameter int              W_ID   = 4,
  parameter int              W_ADR  = 32,
  parameter int              W_DATA = 32,
  parameter logic [W_ID-1:0] AXI_ID = '0
) (
  input  logic                rst_n,
  input  logic                clk,
  // core side
  input  logic                core_req,
  output logic                core_req_ack,
  input  logic                core_cmd,
  input  logic [1:0]          core_width,
  input  logic [W_ADR-1:0]    core_addr,
  input  logic [W_DATA-1:0]   core_wdata,
  output logic [W_DATA-1:0]   core_rdata,
  output logic [1:0]          core_resp,
  // AXI write address
  output logic                awvalid,
  input  logic                awready,
  output logic [W_ID-1:0]     awid,
  output logic [W_ADR-1:0]    awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  // AXI write data
  output logic                wvalid,
  input  logic                wready,
  output logic [W_DATA-1:0]   wdata,
  output logic [W_DATA/8-1:0] wstrb,
  output logic                wlast,
  // AXI write response
  input  logic                bvalid,
  output logic                bready,
  input  logic [W_ID-1:0]     bid,
  input  logic [1:0]          bresp,
  // AXI read address
  output logic                arvalid,
  input  logic                arready,
  output logic [W_ID-1:0]     arid,
  output logic [W_ADR-1:0]    araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  // AXI read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [W_ID-1:0]     rid,
  input  logic [W_DATA-1:0]   rdata,
  input  logic                rlast,
  input  logic [1:0]          rresp
);

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_RD_A, S_RD_D, S_WR, S_WR_B} state_t;

  state_t                state_q, state_d;
  logic [W_ADR-1:0]      addr_q;
  logic [1:0]            width_q;
  logic [W_DATA-1:0]     wdata_q;
  logic [W_DATA/8-1:0]   wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic [W_DATA-1:0]     rdata_q;
  logic [1:0]            resp_q;

  logic                  accept, misaligned;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [W_DATA/8-1:0]   strb_base;
  logic [W_DATA-1:0]     r_shifted, r_extracted;
  logic                  unused_inputs;

  assign accept       = core_req & (state_q == S_IDLE);
  assign core_req_ack = accept;
  assign misaligned   = (core_width == 2'd3)
                      | ((core_width == 2'd1) & core_addr[0])
                      | ((core_width == 2'd2) & (|core_addr[1:0]));

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bvalid  & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid  & rready;

  // Transaction IDs, burst length and rlast carry no information for single beats.
  assign unused_inputs = ^{rid, bid, rlast, bresp[0], rresp[0]};

  always_comb begin
    case (core_width)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      2'd2:    strb_base = 4'b1111;
      default: strb_base = 4'b0000;
    endcase
  end

  always_comb begin
    r_shifted = rdata >> {addr_q[1:0], 3'b000};
    case (width_q)
      2'd0:    r_extracted = {24'd0, r_shifted[7:0]};
      2'd1:    r_extracted = {16'd0, r_shifted[15:0]};
      default: r_extracted = r_shifted;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = misaligned ? S_ERR : (core_cmd ? S_WR : S_RD_A);
      S_ERR:  state_d = S_IDLE;
      S_RD_A: if (ar_hs) state_d = S_RD_D;
      S_RD_D: if (r_hs)  state_d = S_IDLE;
      S_WR:   if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = S_WR_B;
      S_WR_B: if (b_hs)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valids come only from registered state, so they never glitch on input changes.
  always_comb begin
    arvalid = (state_q == S_RD_A);
    rready  = (state_q == S_RD_D);
    awvalid = (state_q == S_WR) & ~aw_done_q;
    wvalid  = (state_q == S_WR) & ~w_done_q;
    bready  = (state_q == S_WR_B);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      width_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_IDLE;
    end else begin
      resp_q <= RESP_IDLE;
      if (accept) begin
        addr_q    <= core_addr;
        width_q   <= core_width;
        wdata_q   <= core_wdata << {core_addr[1:0], 3'b000};
        wstrb_q   <= strb_base << core_addr[1:0];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (misaligned) resp_q <= RESP_ERR;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs) begin
        rdata_q <= r_extracted;
        resp_q  <= rresp[1] ? RESP_ERR : RESP_OK;
      end
      if (b_hs) resp_q <= bresp[1] ? RESP_ERR : RESP_OK;
    end
  end

  assign core_rdata = rdata_q;
  assign core_resp  = resp_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, width_q};
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, width_q};
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

endmodule

// File: tb/tb_scr1_axi_mem_bridge.sv
// Directed bench for scr1_axi_mem_bridge with a small AXI slave memory and
// hand-computed expectations for each scenario.
module tb_scr1_axi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        core_req = 1'b0, core_cmd = 1'b0;
  logic [1:0]  core_width = 2'd0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        core_req_ack;
  logic [31:0] core_rdata;
  logic [1:0]  core_resp;

  logic        awvalid, wvalid, bvalid, bready, arvalid, rvalid, rready, wlast;
  logic        awready = 1'b1, wready = 1'b1, arready = 1'b1;
  logic [3:0]  awid, arid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        r_en = 1'b1, b_en = 1'b1;

  scr1_axi_mem_bridge dut (
    .rst_n(rst_n), .clk(clk),
    .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awsize(awsize), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(4'd0), .bresp(bresp_cfg),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(4'd0), .rdata(rdata),
    .rlast(1'b1), .rresp(rresp_cfg)
  );

  // Slave model: responds in the first cycle the bridge is ready, unless held off.
  logic [31:0] mem [0:255];
  logic [31:0] rd_addr = '0;
  assign bvalid = bready & b_en;
  assign rvalid = rready & r_en;
  assign rdata  = mem[rd_addr[9:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h40] <= 32'hDEADBEEF;
    end else begin
      if (arvalid && arready) rd_addr <= araddr;
      if (wvalid && wready)
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) mem[awaddr[9:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  int ok_cnt = 0, err_cnt = 0, arv_cyc = 0, awv_cyc = 0, wv_cyc = 0, b_hs_cnt = 0;
  always @(posedge clk) begin
    if (core_resp == 2'd1) ok_cnt  <= ok_cnt + 1;
    if (core_resp == 2'd2) err_cnt <= err_cnt + 1;
    if (arvalid) arv_cyc <= arv_cyc + 1;
    if (awvalid) awv_cyc <= awv_cyc + 1;
    if (wvalid)  wv_cyc  <= wv_cyc + 1;
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
  end

  int vectors = 0, miscompares = 0;

  // Presents a request at a falling edge, expects acceptance, and leaves us one cycle later.
  task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    core_req = 1'b1; core_cmd = cmd; core_width = w; core_addr = a; core_wdata = d;
    #1;
    vectors++;
    if (core_req_ack !== 1'b1) begin miscompares++; $display("FAIL req_ack @%h: got %b need 1", a, core_req_ack); end
    @(negedge clk);
    core_req = 1'b0;
  endtask

  // Waits (bounded) for a response pulse; lat counts cycles since acceptance.
  task automatic wait_resp(output int lat, output logic [1:0] r);
    lat = 1;
    while (core_resp === 2'd0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = core_resp;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin miscompares++; $display("FAIL rst_valids: got %b need 00000", {arvalid, awvalid, wvalid, bready, rready}); end
    vectors++;
    if (core_resp !== 2'd0 || core_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_core: got resp %0d rdata %h need 0/0", core_resp, core_rdata); end
    vectors++;
    if (awaddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0 || awsize !== 3'd0) begin miscompares++; $display("FAIL rst_regs: got %h %h %h %h need zeros", awaddr, wdata, wstrb, awsize); end
    vectors++;
    if ({awlen, arlen, awburst, arburst, wlast, awid, arid} !== {8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 4'd0, 4'd0}) begin miscompares++; $display("FAIL rst_const: got len %h/%h burst %b/%b wlast %b id %h/%h", awlen, arlen, awburst, arburst, wlast, awid, arid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_read();
    int lat; logic [1:0] r;
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    vectors++;
    if (arvalid !== 1'b1 || araddr !== 32'h100 || arsize !== 3'd2) begin miscompares++; $display("FAIL word_rd_ar: got v%b %h sz%0d need v1 100 sz2", arvalid, araddr, arsize); end
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || lat !== 3) begin miscompares++; $display("FAIL word_rd_resp: got %0d lat %0d need 1 lat 3", r, lat); end
    vectors++;
    if (core_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_rd_data: got %h need deadbeef", core_rdata); end
    @(negedge clk);
    vectors++;
    if (core_resp !== 2'd0) begin miscompares++; $display("FAIL resp_pulse: got %0d need 0", core_resp); end
  endtask

  task automatic test_byte_write_read();
    int lat, b0; logic [1:0] r;
    b0 = b_hs_cnt;
    issue(1'b1, 2'd0, 32'h103, 32'h0000_00A5);
    vectors++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h103 || awsize !== 3'd0) begin miscompares++; $display("FAIL byte_wr_aw: got v%b%b %h sz%0d need v11 103 sz0", awvalid, wvalid, awaddr, awsize); end
    vectors++;
    if (wstrb !== 4'b1000 || wdata[31:24] !== 8'hA5) begin miscompares++; $display("FAIL byte_wr_lane: got strb %b data %h need 1000 a5xxxxxx", wstrb, wdata); end
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || lat !== 3) begin miscompares++; $display("FAIL byte_wr_resp: got %0d lat %0d need 1 lat 3", r, lat); end
    vectors++;
    if (b_hs_cnt - b0 !== 1) begin miscompares++; $display("FAIL byte_wr_b: got %0d B beats need 1", b_hs_cnt - b0); end
    issue(1'b0, 2'd0, 32'h103, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || core_rdata !== 32'h0000_00A5) begin miscompares++; $display("FAIL byte_rd: got %0d %h need 1 000000a5", r, core_rdata); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int lat, arv0, awv0; logic [1:0] r;
    arv0 = arv_cyc; awv0 = awv_cyc;
    issue(1'b0, 2'd1, 32'h101, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd2 || lat !== 1) begin miscompares++; $display("FAIL half_misalign: got %0d lat %0d need 2 lat 1", r, lat); end
    @(negedge clk);
    vectors++;
    if (core_resp !== 2'd0) begin miscompares++; $display("FAIL err_pulse: got %0d need 0", core_resp); end
    issue(1'b1, 2'd3, 32'h200, 32'h1);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd2 || lat !== 1) begin miscompares++; $display("FAIL width3: got %0d lat %0d need 2 lat 1", r, lat); end
    @(negedge clk);
    vectors++;
    if (arv_cyc - arv0 !== 0 || awv_cyc - awv0 !== 0) begin miscompares++; $display("FAIL err_no_axi: got ar %0d aw %0d need 0 0", arv_cyc - arv0, awv_cyc - awv0); end
  endtask

  task automatic test_aw_stall();
    int lat, awv0, wv0, ok0; logic [1:0] r;
    awv0 = awv_cyc; wv0 = wv_cyc; ok0 = ok_cnt;
    awready = 1'b0;
    issue(1'b1, 2'd2, 32'h200, 32'h1234_5678);
    vectors++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin miscompares++; $display("FAIL stall_c1: got aw%b w%b need 11", awvalid, wvalid); end
    @(negedge clk);
    vectors++;
    if (awvalid !== 1'b1 || wvalid !== 1'b0) begin miscompares++; $display("FAIL stall_c2: got aw%b w%b need 10", awvalid, wvalid); end
    @(negedge clk);
    vectors++;
    if (awvalid !== 1'b1 || awaddr !== 32'h200 || bready !== 1'b0) begin miscompares++; $display("FAIL stall_c3: got aw%b %h b%b need 1 200 0", awvalid, awaddr, bready); end
    @(negedge clk);
    awready = 1'b1;
    wait_resp(lat, r);
    repeat (2) @(negedge clk);
    vectors++;
    if (r !== 2'd1 || ok_cnt - ok0 !== 1) begin miscompares++; $display("FAIL stall_resp: got %0d x%0d need 1 x1", r, ok_cnt - ok0); end
    vectors++;
    if (awv_cyc - awv0 !== 4 || wv_cyc - wv0 !== 1) begin miscompares++; $display("FAIL stall_cycles: got aw %0d w %0d need 4 1", awv_cyc - awv0, wv_cyc - wv0); end
  endtask

  task automatic test_half_rw();
    int lat; logic [1:0] r;
    issue(1'b1, 2'd1, 32'h202, 32'h0000_BEEF);
    vectors++;
    if (wstrb !== 4'b1100 || wdata !== 32'hBEEF_0000 || awsize !== 3'd1) begin miscompares++; $display("FAIL half_wr_lane: got %b %h sz%0d need 1100 beef0000 sz1", wstrb, wdata, awsize); end
    wait_resp(lat, r);
    issue(1'b0, 2'd1, 32'h202, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || core_rdata !== 32'h0000_BEEF) begin miscompares++; $display("FAIL half_rd: got %0d %h need 1 0000beef", r, core_rdata); end
    @(negedge clk);
  endtask

  task automatic test_slave_err();
    int lat; logic [1:0] r;
    bresp_cfg = 2'b10;
    issue(1'b1, 2'd0, 32'h300, 32'h5A);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd2 || lat !== 3) begin miscompares++; $display("FAIL bresp_err: got %0d lat %0d need 2 lat 3", r, lat); end
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd2 || lat !== 3) begin miscompares++; $display("FAIL rresp_err: got %0d lat %0d need 2 lat 3", r, lat); end
    rresp_cfg = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; logic [1:0] r;
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || core_rdata !== 32'hA5AD_BEEF) begin miscompares++; $display("FAIL b2b_first: got %0d %h need 1 a5adbeef", r, core_rdata); end
    issue(1'b0, 2'd2, 32'h200, 32'h0);
    wait_resp(lat, r);
    vectors++;
    if (r !== 2'd1 || lat !== 3 || core_rdata !== 32'hBEEF_5678) begin miscompares++; $display("FAIL b2b_second: got %0d lat %0d %h need 1 lat 3 beef5678", r, lat, core_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ok0, err0;
    r_en = 1'b0;
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    vectors++;
    if (rready !== 1'b1) begin miscompares++; $display("FAIL mid_rd_d: got rready %b need 1", rready); end
    ok0 = ok_cnt; err0 = err_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rready, arvalid, awvalid, wvalid, bready} !== 5'b0 || core_resp !== 2'd0 || core_rdata !== 32'd0 || araddr !== 32'd0) begin miscompares++; $display("FAIL mid_reset: got %b resp %0d %h %h need zeros", {rready, arvalid, awvalid, wvalid, bready}, core_resp, core_rdata, araddr); end
    @(negedge clk);
    rst_n = 1'b1; r_en = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 0 || rready !== 1'b0) begin miscompares++; $display("FAIL mid_no_resp: got ok %0d err %0d rready %b need 0 0 0", ok_cnt - ok0, err_cnt - err0, rready); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write_read();
    test_misaligned();
    test_aw_stall();
    test_half_rw();
    test_slave_err();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
